// File: rtl/vga_timing_rx.sv
// Purpose : sink for the VGA/XGA timing stream. Regenerates pixel coordinates and
//           frame/line markers, measures line and frame timing, and flags a stable lock.
// Latency : pixel outputs 2 vga_clk cycles after the inputs. Measurements update 2 cycles after the causing input edge.
// Backpressure: none. The stream is consumed every cycle and there is no ready signal.
//
// Ports:
//   vga_clk, rst_n               pixel clock, asynchronous active-low reset
//   h_sync, v_sync               active-low syncs
//   pixel_de, rgb_in             active-video enable and {r,g,b} pixel data
//   pix_valid, pix_data          registered de/pixel (data forced to 0 outside active video)
//   pix_x, pix_y, sof, eol       coordinates of the current pixel, start-of-frame / end-of-line pulses
//   line_period, h_active,       measurements of the last completed line/frame
//   v_active, frame_lines
//   locked, err                  timing stable, one-cycle pulse on loss of lock
module vga_timing_rx #(
  parameter int CNT_W       = 11,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic             h_sync,
  input  logic             v_sync,
  input  logic             pixel_de,
  input  logic [23:0]      rgb_in,
  output logic             pix_valid,
  output logic [23:0]      pix_data,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             sof,
  output logic             eol,
  output logic [CNT_W-1:0] line_period,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active,
  output logic [CNT_W-1:0] frame_lines,
  output logic             locked,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    CHECK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  // One frame's worth of timing measurements, compared as a single word.
  typedef struct packed {
    logic [CNT_W-1:0] line_period;
    logic [CNT_W-1:0] h_active;
    logic [CNT_W-1:0] v_active;
    logic [CNT_W-1:0] frame_lines;
  } meas_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // ---------------------------------------------------------------------------
  // Input stage: stage 1 samples the pins, stage 2 keeps the previous sample.
  // ---------------------------------------------------------------------------
  logic        s1_hs, s1_vs, s1_de;
  logic [23:0] s1_rgb;
  logic        s2_hs, s2_vs, s2_de;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hs  <= 1'b1;
      s1_vs  <= 1'b1;
      s1_de  <= 1'b0;
      s1_rgb <= '0;
      s2_hs  <= 1'b0;
      s2_vs  <= 1'b0;
      s2_de  <= 1'b0;
    end else begin
      s1_hs  <= h_sync;
      s1_vs  <= v_sync;
      s1_de  <= pixel_de;
      s1_rgb <= rgb_in;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      s2_de  <= s1_de;
    end
  end

  logic hs_fall, vs_fall, de_rise, de_fall;

  assign hs_fall = s2_hs & ~s1_hs;
  assign vs_fall = s2_vs & ~s1_vs;
  assign de_rise = ~s2_de & s1_de;
  assign de_fall = s2_de & ~s1_de;

  // ---------------------------------------------------------------------------
  // Horizontal counter and line period.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] period_meas;

  // Length of the line that ends at this hsync fall, counting the fall cycle itself.
  assign period_meas = sat_inc(hcnt);

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt        <= '0;
      line_period <= '0;
    end else if (hs_fall) begin
      line_period <= period_meas;
      hcnt        <= '0;
    end else begin
      hcnt        <= sat_inc(hcnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Line counter, frame height and active height.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] lcnt;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt        <= '0;
      frame_lines <= '0;
      v_active    <= '0;
    end else if (vs_fall) begin
      // A coincident hsync fall is the first line of the new frame,
      // so it is not included in the count that is latched here.
      frame_lines <= lcnt;
      v_active    <= pix_y;
      lcnt        <= hs_fall ? CNT_ONE : '0;
    end else if (hs_fall) begin
      lcnt        <= sat_inc(lcnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel path: coordinates, markers and active width.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] x_nxt, y_nxt;

  always_comb begin
    x_nxt = pix_x;
    if (de_rise)    x_nxt = '0;
    else if (s1_de) x_nxt = sat_inc(pix_x);

    y_nxt = pix_y;
    if (vs_fall)      y_nxt = '0;
    else if (de_fall) y_nxt = sat_inc(pix_y);
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      h_active  <= '0;
    end else begin
      pix_valid <= s1_de;
      pix_data  <= s1_de ? s1_rgb : 24'd0;
      pix_x     <= x_nxt;
      pix_y     <= y_nxt;
      sof       <= de_rise & (y_nxt == '0);
      // The pin value is one pixel ahead of stage 1. Using it as a lookahead
      // flags the last active pixel without adding a pipeline stage.
      eol       <= s1_de & ~pixel_de;
      // pix_x still holds the column of the last active pixel here.
      if (de_fall) h_active <= sat_inc(pix_x);
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM.
  // ---------------------------------------------------------------------------
  // Set as it will be after this cycle's latches, because the hsync fall that
  // closes the last line usually coincides with the vsync fall.
  meas_t meas_nxt;

  assign meas_nxt = {(hs_fall ? period_meas : line_period),
                     (de_fall ? sat_inc(pix_x) : h_active),
                     pix_y,
                     lcnt};

  state_t     state, state_nxt;
  meas_t      ref_q, ref_nxt;
  logic [3:0] mcnt, mcnt_nxt, mcnt_inc;
  logic       lost;

  assign mcnt_inc = mcnt + 4'd1;

  // Lock is lost on a line of the wrong length, a frame that no longer matches,
  // or an hsync that stops arriving.
  assign lost = (hs_fall && (period_meas != ref_q.line_period)) ||
                (vs_fall && (meas_nxt != ref_q)) ||
                (hcnt == CNT_MAX);

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ref_q  <= '0;
      mcnt   <= '0;
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      ref_q  <= ref_nxt;
      mcnt   <= mcnt_nxt;
      locked <= (state_nxt == LOCKED);
      err    <= (state == LOCKED) && lost;
    end
  end

  always_comb begin
    state_nxt = state;
    ref_nxt   = ref_q;
    mcnt_nxt  = mcnt;
    case (state)
      IDLE: begin
        // The frame in progress when we woke up is incomplete, so only start
        // measuring at the next frame boundary.
        if (vs_fall) state_nxt = ACQ;
      end
      ACQ: begin
        if (vs_fall) begin
          ref_nxt   = meas_nxt;
          mcnt_nxt  = '0;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (vs_fall) begin
          if (meas_nxt == ref_q) begin
            mcnt_nxt = mcnt_inc;
            if (mcnt_inc == LOCK_N) state_nxt = LOCKED;
          end else begin
            ref_nxt  = meas_nxt;
            mcnt_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (lost) begin
          mcnt_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx: drives scaled-down VGA-style frames with random pixel data.
// Expected coordinates, markers and measurements come from the frame geometry.
// A second instance with LOCK_FRAMES=1 shares the same input stream.
module tb_vga_timing_rx;

  localparam int CNT_W = 11;

  logic             vga_clk;
  logic             rst_n;
  logic             h_sync, v_sync, pixel_de;
  logic [23:0]      rgb_in;

  logic             pix_valid, sof, eol, locked, err;
  logic [23:0]      pix_data;
  logic [CNT_W-1:0] pix_x, pix_y, line_period, h_active, v_active, frame_lines;

  logic             d1_pix_valid, d1_sof, d1_eol, d1_locked, d1_err;
  logic [23:0]      d1_pix_data;
  logic [CNT_W-1:0] d1_pix_x, d1_pix_y, d1_line_period, d1_h_active, d1_v_active, d1_frame_lines;

  vga_timing_rx #(.CNT_W(CNT_W), .LOCK_FRAMES(2)) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .h_sync(h_sync), .v_sync(v_sync),
    .pixel_de(pixel_de), .rgb_in(rgb_in),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .sof(sof), .eol(eol), .line_period(line_period), .h_active(h_active),
    .v_active(v_active), .frame_lines(frame_lines), .locked(locked), .err(err)
  );

  vga_timing_rx #(.CNT_W(CNT_W), .LOCK_FRAMES(1)) dut1 (
    .vga_clk(vga_clk), .rst_n(rst_n), .h_sync(h_sync), .v_sync(v_sync),
    .pixel_de(pixel_de), .rgb_in(rgb_in),
    .pix_valid(d1_pix_valid), .pix_data(d1_pix_data), .pix_x(d1_pix_x), .pix_y(d1_pix_y),
    .sof(d1_sof), .eol(d1_eol), .line_period(d1_line_period), .h_active(d1_h_active),
    .v_active(d1_v_active), .frame_lines(d1_frame_lines), .locked(d1_locked), .err(d1_err)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  typedef struct {
    logic        vld;
    logic [23:0] rgb;
    int          x;
    int          y;
    logic        sof;
    logic        eol;
  } exp_t;

  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   rise_cyc = -1, d1_rise = -1;
  int   err_cyc = -1, d1_err_cyc = -1;
  int   err_cnt = 0, d1_err_cnt = 0;
  int   mark_cyc = -1;
  logic prev_lk = 1'b0, d1_prev_lk = 1'b0;
  int   vsf_q[$];
  exp_t ec, e1, e2;

  // Current frame geometry: total, sync width, de start, de length (h then v).
  int ht, hsw, hde0, ha, vt, vsw, vde0, va;

  task automatic set_fmt(input int a, b, c, d, e, f, g, h);
    ht = a; hsw = b; hde0 = c; ha = d; vt = e; vsw = f; vde0 = g; va = h;
  endtask

  function automatic void gen(input int l, h, output logic hs, vs, de);
    hs = !(h < hsw);
    vs = !(l < vsw);
    de = (l >= vde0) && (l < vde0 + va) && (h >= hde0) && (h < hde0 + ha);
  endfunction

  // One pixel clock: observe at the falling edge, then drive the next inputs.
  task automatic tick(input logic hs, vs, de, input logic [23:0] rgb, input int x, y);
    @(negedge vga_clk);
    cyc++;
    if (locked === 1'b1 && !prev_lk) rise_cyc = cyc;
    prev_lk = (locked === 1'b1);
    if (d1_locked === 1'b1 && !d1_prev_lk) d1_rise = cyc;
    d1_prev_lk = (d1_locked === 1'b1);
    if (err === 1'b1) begin err_cnt++; err_cyc = cyc; end
    if (d1_err === 1'b1) begin d1_err_cnt++; d1_err_cyc = cyc; end
    e2 = e1;
    e1 = ec;
    ec.vld = de;
    ec.rgb = de ? rgb : 24'd0;
    ec.x   = x;
    ec.y   = y;
    ec.sof = de && x == 0 && y == 0;
    ec.eol = de && x == ha - 1;
    if (v_sync === 1'b1 && vs === 1'b0) vsf_q.push_back(cyc);
    h_sync   = hs;
    v_sync   = vs;
    pixel_de = de;
    rgb_in   = rgb;
  endtask

  // Drives one frame. short_line loses its last cycle. mark_cyc records the
  // cycle whose drive starts mark_line.
  task automatic run_frame(input int short_line, input int mark_line);
    logic hs, vs, de;
    int   len;
    for (int l = 0; l < vt; l++) begin
      len = (l == short_line) ? ht - 1 : ht;
      for (int h = 0; h < len; h++) begin
        gen(l, h, hs, vs, de);
        tick(hs, vs, de, 24'($urandom), h - hde0, l - vde0);
        if (l == mark_line && h == 0) mark_cyc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge vga_clk);
    nvec++;
    if ({pix_valid, pix_data, pix_x, pix_y, sof, eol} !== '0)
      begin nerr++; $display("FAIL reset_pix: got %h required 0", {pix_valid, pix_data, pix_x, pix_y, sof, eol}); end
    nvec++;
    if ({line_period, h_active, v_active, frame_lines} !== '0)
      begin nerr++; $display("FAIL reset_meas: got %h required 0", {line_period, h_active, v_active, frame_lines}); end
    nvec++;
    if ({locked, err, d1_locked, d1_err} !== 4'b0)
      begin nerr++; $display("FAIL reset_lock: got %b required 0000", {locked, err, d1_locked, d1_err}); end
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    vsf_q.delete();
    set_fmt(40, 4, 8, 24, 12, 2, 3, 6);
    repeat (5) run_frame(-1, -1);
    nvec++;
    if (vsf_q.size() != 5 || rise_cyc != vsf_q[3] + 2)
      begin nerr++; $display("FAIL lock_latency: rose at cycle %0d, required 2 after 4th vsync fall", rise_cyc); end
    nvec++;
    if (vsf_q.size() != 5 || d1_rise != vsf_q[2] + 2)
      begin nerr++; $display("FAIL lock1_latency: rose at cycle %0d, required 2 after 3rd vsync fall", d1_rise); end
    nvec++;
    if (line_period !== 11'(ht) || h_active !== 11'(ha))
      begin nerr++; $display("FAIL lock_hmeas: got %0d/%0d required %0d/%0d", line_period, h_active, ht, ha); end
    nvec++;
    if (v_active !== 11'(va) || frame_lines !== 11'(vt))
      begin nerr++; $display("FAIL lock_vmeas: got %0d/%0d required %0d/%0d", v_active, frame_lines, va, vt); end
    nvec++;
    if (locked !== 1'b1 || err_cnt != 0 || d1_err_cnt != 0)
      begin nerr++; $display("FAIL lock_state: locked=%b errs=%0d/%0d required 1 with no err", locked, err_cnt, d1_err_cnt); end
  endtask

  task automatic test_coords();
    logic hs, vs, de;
    int   nsof = 0;
    int   neol = 0;
    int   e0 = err_cnt;
    for (int l = 0; l < vt; l++) begin
      for (int h = 0; h < ht; h++) begin
        gen(l, h, hs, vs, de);
        tick(hs, vs, de, 24'($urandom), h - hde0, l - vde0);
        if (e2.vld) begin
          nvec++;
          if (pix_valid !== 1'b1 || pix_data !== e2.rgb)
            begin nerr++; $display("FAIL pix_data: got %b/%h required 1/%h", pix_valid, pix_data, e2.rgb); end
          nvec++;
          if (pix_x !== 11'(e2.x) || pix_y !== 11'(e2.y))
            begin nerr++; $display("FAIL pix_xy: got %0d,%0d required %0d,%0d", pix_x, pix_y, e2.x, e2.y); end
          nvec++;
          if (sof !== e2.sof || eol !== e2.eol)
            begin nerr++; $display("FAIL markers: sof/eol got %b%b required %b%b at %0d,%0d", sof, eol, e2.sof, e2.eol, e2.x, e2.y); end
        end else begin
          nvec++;
          if ({pix_valid, pix_data, sof, eol} !== '0)
            begin nerr++; $display("FAIL blank: got %h required 0", {pix_valid, pix_data, sof, eol}); end
        end
        if (sof === 1'b1) nsof++;
        if (eol === 1'b1) neol++;
      end
    end
    nvec++;
    if (nsof != 1 || neol != va)
      begin nerr++; $display("FAIL marker_count: sof=%0d eol=%0d required 1/%0d", nsof, neol, va); end
    nvec++;
    if (locked !== 1'b1 || err_cnt != e0)
      begin nerr++; $display("FAIL coords_lock: locked=%b err delta %0d required 1/0", locked, err_cnt - e0); end
  endtask

  task automatic test_short_line();
    int e0  = err_cnt;
    int e10 = d1_err_cnt;
    run_frame(4, 5);
    nvec++;
    if (err_cnt != e0 + 1 || err_cyc != mark_cyc + 2)
      begin nerr++; $display("FAIL short_err: %0d pulses at cycle %0d, required 1 at %0d", err_cnt - e0, err_cyc, mark_cyc + 2); end
    nvec++;
    if (d1_err_cnt != e10 + 1 || locked !== 1'b0 || d1_locked !== 1'b0)
      begin nerr++; $display("FAIL short_drop: d1 pulses %0d locked %b%b required 1 and 00", d1_err_cnt - e10, locked, d1_locked); end
    vsf_q.delete();
    rise_cyc = -1;
    d1_rise  = -1;
    repeat (4) run_frame(-1, -1);
    nvec++;
    if (vsf_q.size() != 4 || d1_rise != vsf_q[2] + 2)
      begin nerr++; $display("FAIL short_relock1: rose at %0d required 2 after 3rd vsync fall", d1_rise); end
    nvec++;
    if (vsf_q.size() != 4 || rise_cyc != vsf_q[3] + 2)
      begin nerr++; $display("FAIL short_relock: rose at %0d required 2 after 4th vsync fall", rise_cyc); end
  endtask

  task automatic test_switch();
    int e0 = err_cnt;
    int t  = $urandom_range(28, 36);
    int v  = $urandom_range(9, 14);
    set_fmt(t, 3, 5, t - 10, v, 2, 2, v - 4);
    run_frame(-1, 1);
    nvec++;
    if (err_cnt != e0 + 1 || err_cyc != mark_cyc + 2)
      begin nerr++; $display("FAIL switch_err: %0d pulses at %0d, required 1 at %0d", err_cnt - e0, err_cyc, mark_cyc + 2); end
    nvec++;
    if (locked !== 1'b0)
      begin nerr++; $display("FAIL switch_drop: locked=%b required 0", locked); end
    vsf_q.delete();
    rise_cyc = -1;
    repeat (5) run_frame(-1, -1);
    nvec++;
    if (vsf_q.size() != 5 || rise_cyc != vsf_q[3] + 2 || locked !== 1'b1)
      begin nerr++; $display("FAIL switch_relock: rose at %0d locked=%b required 2 after 4th fall", rise_cyc, locked); end
    nvec++;
    if (line_period !== 11'(ht) || h_active !== 11'(ha) || v_active !== 11'(va) || frame_lines !== 11'(vt))
      begin nerr++; $display("FAIL switch_meas: got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
                             line_period, h_active, v_active, frame_lines, ht, ha, va, vt); end
  endtask

  task automatic test_sync_loss();
    int e0  = err_cnt;
    int e10 = d1_err_cnt;
    run_frame(-1, vt - 1);
    for (int i = 0; i < 2100; i++) begin
      tick(1'b1, 1'b1, 1'b0, 24'($urandom), 0, 0);
      if (cyc == mark_cyc + 2000) begin
        nvec++;
        if (locked !== 1'b1)
          begin nerr++; $display("FAIL loss_early: locked=%b required 1 before saturation", locked); end
      end
    end
    nvec++;
    if (err_cnt != e0 + 1 || err_cyc < mark_cyc + 2040 || err_cyc > mark_cyc + 2060)
      begin nerr++; $display("FAIL loss_err: %0d pulses, at +%0d, required 1 near +2050", err_cnt - e0, err_cyc - mark_cyc); end
    nvec++;
    if (locked !== 1'b0 || d1_locked !== 1'b0 || d1_err_cnt != e10 + 1)
      begin nerr++; $display("FAIL loss_drop: locked %b%b d1 pulses %0d required 00/1", locked, d1_locked, d1_err_cnt - e10); end
    nvec++;
    if (line_period !== 11'(ht))
      begin nerr++; $display("FAIL loss_period: got %0d required %0d", line_period, ht); end
  endtask

  task automatic test_reset_mid();
    repeat (5) run_frame(-1, -1);
    nvec++;
    if (locked !== 1'b1)
      begin nerr++; $display("FAIL premid_lock: locked=%b required 1", locked); end
    fork
      run_frame(-1, -1);
      begin
        repeat (ht * 3 + 7) @(negedge vga_clk);
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({pix_valid, pix_data, pix_x, pix_y, sof, eol, locked, err} !== '0)
          begin nerr++; $display("FAIL mid_pix: got %h required 0", {pix_valid, pix_data, pix_x, pix_y, sof, eol, locked, err}); end
        nvec++;
        if ({line_period, h_active, v_active, frame_lines, d1_locked, d1_line_period} !== '0)
          begin nerr++; $display("FAIL mid_meas: got %h required 0", {line_period, h_active, v_active, frame_lines, d1_locked, d1_line_period}); end
        vsf_q.delete();
        rise_cyc = -1;
        d1_rise  = -1;
        @(negedge vga_clk);
        rst_n = 1'b1;
      end
    join
    repeat (5) run_frame(-1, -1);
    nvec++;
    if (vsf_q.size() != 5 || rise_cyc != vsf_q[3] + 2)
      begin nerr++; $display("FAIL mid_relock: rose at %0d required 2 after 4th vsync fall", rise_cyc); end
    nvec++;
    if (vsf_q.size() != 5 || d1_rise != vsf_q[2] + 2)
      begin nerr++; $display("FAIL mid_relock1: rose at %0d required 2 after 3rd vsync fall", d1_rise); end
  endtask

  initial begin
    rst_n    = 1'b0;
    h_sync   = 1'b1;
    v_sync   = 1'b1;
    pixel_de = 1'b0;
    rgb_in   = 24'd0;
    ec = '{vld: 1'b0, rgb: 24'd0, x: 0, y: 0, sof: 1'b0, eol: 1'b0};
    e1 = ec;
    e2 = ec;
    test_reset();
    test_lock();
    test_coords();
    test_short_line();
    test_switch();
    test_sync_loss();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", nvec, nerr);
    $fatal(1);
  end

endmodule
